sid_write_arbiter: RTL and testbench
====================================

SID_WRITE_ARBITER -- requirements
Module: sid_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (one per SID voice); legal values 1..3.
REQ-002 SHALL have parameter GAP, default 0, idle cycles inserted after each completed write; legal values 0..15.
REQ-003 SHALL have port clk  in  1  system clock (50 MHz); all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester write request.
REQ-006 SHALL have port req_addr  in  3*NREQ  per-requester register address; requester i uses bits [3i+2:3i].
REQ-007 SHALL have port req_data  in  8*NREQ  per-requester register data; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port req_ready  out  NREQ  per-requester accept strobe.
REQ-009 SHALL have port bus_ctrl  out  8  SID control byte {we, 2'b00, voice[1:0], addr[2:0]}.
REQ-010 SHALL have port bus_data  out  8  SID write data.
REQ-011 SHALL have port busy  out  1  high while the state is not IDLE.
REQ-012 SHALL have port wr_done  out  1  one-cycle pulse in the HOLD cycle of each write.

Function
REQ-013 SHALL implement the states IDLE, SETUP, STROBE, HOLD and GAPWAIT.
REQ-014 SHALL, in IDLE, grant the asserted requester with highest round-robin priority: requester (last+1) mod NREQ first, then ascending with wrap-around.
REQ-015 SHALL drive req_ready combinationally as one-hot: high only for the granted requester, only in IDLE; all bits 0 in every other state.
REQ-016 SHALL accept a request on the edge where req_valid[i] and req_ready[i] are both high, capture its addr and data, set voice = i and last = i, and enter SETUP.
REQ-017 SHALL drive bus_ctrl and bus_data from registers only; no combinational path from req_* to bus_*.
REQ-018 SHALL, with acceptance at edge T, present the captured voice, addr and data with we=0 during cycle T+1 (SETUP).
REQ-019 SHALL assert we=1 during cycle T+2 (STROBE), with voice, addr and data unchanged.
REQ-020 SHALL deassert we during cycle T+3 (HOLD) and pulse wr_done in that cycle.
REQ-021 SHALL, after HOLD, enter GAPWAIT for exactly GAP cycles, then IDLE; with GAP=0 it SHALL go directly to IDLE.
REQ-022 SHALL therefore accept back-to-back writes at most once every 4+GAP cycles.
REQ-023 SHALL keep bus_ctrl[6:0] and bus_data at the last-written values while idle; bus_ctrl[7] SHALL be high only in STROBE.
REQ-024 SHALL treat a req_valid that drops before acceptance as withdrawn, with no write issued.
REQ-025 SHALL ignore changes to req_addr and req_data after acceptance.
REQ-026 SHALL issue no write when the selected requester index is >= NREQ.
REQ-027 SHALL make req_valid asserted in non-IDLE states wait until the next IDLE; no request is lost or duplicated.
REQ-028 SHALL, when only one requester is valid, grant it regardless of the round-robin pointer.

Reset
REQ-029 SHALL, on rst_n low, immediately (asynchronously) set the state to IDLE, bus_ctrl=0x00, bus_data=0x00, busy=0, wr_done=0 and last=NREQ-1.
REQ-030 SHALL abandon any write in progress when reset asserts mid-write, including during STROBE, with we falling without waiting for a clock edge.
REQ-031 SHALL accept requests on the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL place the state encoding, the bus_ctrl bit positions (WE=7, VOICE=4:3, ADDR=2:0) and the SID register address constants (FREQ_LO=0 .. CTRL=6) in the shared package sid_pkg.
REQ-033 SHALL contain one sub-module, sid_rr_arbiter, that computes the round-robin one-hot grant from req_valid and last; the FSM and the bus registers SHALL remain in the top module.

Verification
REQ-034 SHALL cover single write: requester 1 with addr=0, data=0x10 -> bus_ctrl=0x08 then 0x88 then 0x08 on cycles T+1..T+3, bus_data=0x10, wr_done in T+3.
REQ-035 SHALL cover contention: all three requesters valid continuously after reset -> grant order 0,1,2,0,1,2, with accepts 4 cycles apart (GAP=0).
REQ-036 SHALL cover GAP: GAP=3 with two queued writes -> second acceptance 7 cycles after the first.
REQ-037 SHALL cover mid-write reset: rst_n low during STROBE -> bus_ctrl=0x00 immediately, and the next accepted write after release starts with requester 0.
REQ-038 SHALL cover voice program: requester 2 issues writes 0x10, 0x00, 0x80, 0x00, 0x0F, 0x21 to addresses 0, 1, 2, 4, 5, 6 -> six STROBE cycles with bus_ctrl 0x90, 0x91, 0x92, 0x94, 0x95, 0x96 and matching bus_data, in order.
REQ-039 SHALL cover withdrawal: req_valid[1] pulses only in a non-IDLE cycle -> no write for requester 1.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared types and constants for the SID register write path.
// Holds the FSM encoding, control-byte field positions and SID voice register map.
package sid_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StGapWait
    } sid_state_e;

    localparam int unsigned CtrlWe      = 7;
    localparam int unsigned CtrlVoiceHi = 4;
    localparam int unsigned CtrlVoiceLo = 3;
    localparam int unsigned CtrlAddrHi  = 2;
    localparam int unsigned CtrlAddrLo  = 0;

    typedef enum logic [2:0] {
        RegFreqLo = 3'd0,
        RegFreqHi = 3'd1,
        RegPwLo   = 3'd2,
        RegPwHi   = 3'd3,
        RegAd     = 3'd4,
        RegSr     = 3'd5,
        RegCtrl   = 3'd6
    } sid_reg_e;

    function automatic logic [7:0] sid_ctrl(input logic we, input logic [1:0] voice,
                                            input logic [2:0] addr);
        logic [7:0] c;
        c                          = '0;
        c[CtrlWe]                  = we;
        c[CtrlVoiceHi:CtrlVoiceLo] = voice;
        c[CtrlAddrHi:CtrlAddrLo]   = addr;
        return c;
    endfunction

endpackage

// File: rtl/sid_rr_arbiter.sv
// Round-robin one-hot grant: requester (last+1) mod NREQ has top priority, then ascending
// with wrap-around.
module sid_rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [1:0]      last,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        // Walk from lowest to highest priority so the highest-priority hit is written last.
        for (int k = int'(NREQ); k >= 1; k--) begin
            idx = (int'(last) + k) % int'(NREQ);
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sid_write_arbiter.sv
// Arbitrates SID voice register writes onto a single registered bus, issuing a
// SETUP / STROBE / HOLD sequence per write with an optional idle gap afterwards.
module sid_write_arbiter
    import sid_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned GAP  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        bus_ctrl,
    output logic [7:0]        bus_data,
    output logic              busy,
    output logic              wr_done
);

    localparam logic [1:0] LastInit = 2'(NREQ - 1);
    localparam logic [3:0] GapLoad  = 4'((GAP > 0) ? GAP - 1 : 0);

    sid_state_e      state;
    logic [1:0]      last;
    logic [3:0]      gap_cnt;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [1:0]      sel_idx;
    logic [2:0]      sel_addr;
    logic [7:0]      sel_data;

    sid_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_valid (req_valid),
        .last      (last),
        .grant     (grant)
    );

    assign req_ready = (state == StIdle) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign busy      = (state != StIdle);

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                sel_idx  = 2'(i);
                sel_addr = req_addr[3*i +: 3];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            last     <= LastInit;
            gap_cnt  <= '0;
            bus_ctrl <= '0;
            bus_data <= '0;
            wr_done  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        bus_ctrl <= sid_ctrl(1'b0, sel_idx, sel_addr);
                        bus_data <= sel_data;
                        last     <= sel_idx;
                        state    <= StSetup;
                    end
                end
                StSetup: begin
                    bus_ctrl[CtrlWe] <= 1'b1;
                    state            <= StStrobe;
                end
                StStrobe: begin
                    bus_ctrl[CtrlWe] <= 1'b0;
                    wr_done          <= 1'b1;
                    state            <= StHold;
                end
                StHold: begin
                    if (GAP == 0) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= GapLoad;
                        state   <= StGapWait;
                    end
                end
                StGapWait: begin
                    if (gap_cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_write_arbiter.sv
// Directed bench for sid_write_arbiter: one GAP=0 instance for most scenarios and a
// GAP=3 instance for write spacing.
module tb_sid_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid, req_ready, g_valid, g_ready;
    logic [8:0]  req_addr, g_addr;
    logic [23:0] req_data, g_data;
    logic [7:0]  bus_ctrl, bus_data, g_ctrl, g_bdata;
    logic        busy, wr_done, g_busy, g_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Strobe log entries: {cycle stamp[15:0], bus_ctrl, bus_data}
    logic [31:0] slog[$];
    logic [31:0] glog[$];

    logic [2:0] pa[6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [7:0] pd[6] = '{8'h10, 8'h00, 8'h80, 8'h00, 8'h0F, 8'h21};
    logic [7:0] cexp[3] = '{8'h81, 8'h8A, 8'h93};
    logic [7:0] dexp[3] = '{8'h11, 8'h22, 8'h33};

    sid_write_arbiter #(
        .NREQ (3),
        .GAP  (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .bus_ctrl  (bus_ctrl),
        .bus_data  (bus_data),
        .busy      (busy),
        .wr_done   (wr_done)
    );

    sid_write_arbiter #(
        .NREQ (3),
        .GAP  (3)
    ) dut_gap (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (g_valid),
        .req_addr  (g_addr),
        .req_data  (g_data),
        .req_ready (g_ready),
        .bus_ctrl  (g_ctrl),
        .bus_data  (g_bdata),
        .busy      (g_busy),
        .wr_done   (g_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (bus_ctrl[7]) slog.push_back({cyc[15:0], bus_ctrl, bus_data});
        if (g_ctrl[7])   glog.push_back({cyc[15:0], g_ctrl, g_bdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] sent(input int i);
        return (i < slog.size()) ? slog[i] : 32'hx;
    endfunction

    function automatic logic [31:0] gent(input int i);
        return (i < glog.size()) ? glog[i] : 32'hx;
    endfunction

    initial begin
        logic [31:0] e0, e1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        g_valid   = '0;
        g_addr    = '0;
        g_data    = '0;
        step(2);

        // Reset state
        check("rst_bus_ctrl", bus_ctrl, 8'h00);
        check("rst_bus_data", bus_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_done", wr_done, 1'b0);
        check("rst_ready", req_ready, 3'b000);

        // Single write from requester 1 on the first edge after reset release
        rst_n          = 1'b1;
        req_addr[5:3]  = 3'd0;
        req_data[15:8] = 8'h10;
        req_valid      = 3'b010;
        #1;
        check("single_ready", req_ready, 3'b010);
        step(1);
        req_valid      = 3'b000;
        req_data[15:8] = 8'hFF;
        req_addr[5:3]  = 3'd7;
        check("single_setup_ctrl", bus_ctrl, 8'h08);
        check("single_setup_data", bus_data, 8'h10);
        check("single_setup_busy", busy, 1'b1);
        check("single_setup_ready", req_ready, 3'b000);
        step(1);
        check("single_strobe_ctrl", bus_ctrl, 8'h88);
        check("single_strobe_data", bus_data, 8'h10);
        check("single_strobe_done", wr_done, 1'b0);
        step(1);
        check("single_hold_ctrl", bus_ctrl, 8'h08);
        check("single_hold_done", wr_done, 1'b1);
        check("single_hold_data", bus_data, 8'h10);
        step(1);
        check("single_idle_busy", busy, 1'b0);
        check("single_idle_done", wr_done, 1'b0);
        check("single_idle_ctrl", bus_ctrl, 8'h08);
        check("single_idle_data", bus_data, 8'h10);

        // Withdrawal: requester 1 pulses only while the bus is busy
        slog.delete();
        req_addr[2:0] = 3'd3;
        req_data[7:0] = 8'h33;
        req_valid     = 3'b001;
        step(1);
        req_valid = 3'b010;
        step(1);
        req_valid = 3'b000;
        step(8);
        check("withdraw_count", slog.size(), 1);
        e0 = sent(0);
        check("withdraw_only_r0", e0[15:0], 16'h8333);

        // Mid-write reset during STROBE (requester 0, last becomes 0)
        req_addr[2:0] = 3'd5;
        req_data[7:0] = 8'h55;
        req_valid     = 3'b001;
        step(1);
        req_valid = 3'b000;
        step(1);
        check("midrst_strobe_ctrl", bus_ctrl, 8'h85);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl_async", bus_ctrl, 8'h00);
        check("midrst_data_async", bus_data, 8'h00);
        check("midrst_busy_async", busy, 1'b0);
        req_addr = {3'd3, 3'd2, 3'd1};
        req_data = {8'h33, 8'h22, 8'h11};

        // Contention from reset release: order 0,1,2,0,1,2 every 4 cycles
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 3'b111;
        slog.delete();
        #1;
        check("contend_first_ready", req_ready, 3'b001);
        @(negedge clk);
        check("contend_first_busy", busy, 1'b1);
        check("contend_first_ctrl", bus_ctrl, 8'h01);
        step(23);
        req_valid = 3'b000;
        step(8);
        check("contend_count", slog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            e0 = sent(i);
            check($sformatf("contend_w%0d", i), e0[15:0], {cexp[i%3], dexp[i%3]});
        end
        for (int i = 1; i < 6; i++) begin
            e0 = sent(i - 1);
            e1 = sent(i);
            check($sformatf("contend_gap%0d", i), 32'(e1[31:16] - e0[31:16]), 4);
        end

        // Voice program from requester 2 only
        slog.delete();
        for (int i = 0; i < 6; i++) begin
            req_addr[8:6]   = pa[i];
            req_data[23:16] = pd[i];
            req_valid       = 3'b100;
            step(1);
            req_valid = 3'b000;
            step(3);
        end
        step(2);
        check("voice_count", slog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            e0 = sent(i);
            check($sformatf("voice_w%0d", i), e0[15:0], {5'b10010, pa[i], pd[i]});
        end

        // GAP=3: second acceptance 7 cycles after the first
        glog.delete();
        g_addr  = {3'd0, 3'd3, 3'd2};
        g_data  = {8'h00, 8'hD3, 8'hC2};
        g_valid = 3'b011;
        step(1);
        g_valid = 3'b010;
        step(10);
        g_valid = 3'b000;
        step(12);
        check("gap_count", glog.size(), 2);
        e0 = gent(0);
        e1 = gent(1);
        check("gap_w0", e0[15:0], 16'h82C2);
        check("gap_w1", e1[15:0], 16'h8BD3);
        check("gap_spacing", 32'(e1[31:16] - e0[31:16]), 7);
        check("gap_idle_busy", g_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
